// File: rtl/divider_pkg.sv
// rtl/divider_pkg.sv - shared widths and FSM encoding for the restoring divider
package divider_pkg;

  localparam int DIVIDEND_W_DEF = 8;
  localparam int DIVISOR_W_DEF  = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } div_state_t;

endpackage

// File: rtl/div_step.sv
// rtl/div_step.sv - one restoring trial subtract-and-compare, purely combinational
module div_step
  import divider_pkg::*;
#(
  parameter int DIVISOR_W = DIVISOR_W_DEF
) (
  input  logic [DIVISOR_W:0]   r_in,
  input  logic [DIVISOR_W-1:0] divisor,
  output logic [DIVISOR_W-1:0] r_out,
  output logic                 q_bit
);

  // After a successful subtract the result is below divisor, so it always fits DIVISOR_W bits.
  always_comb begin
    q_bit = (r_in >= {1'b0, divisor});
    r_out = q_bit ? DIVISOR_W'(r_in - {1'b0, divisor}) : r_in[DIVISOR_W-1:0];
  end

endmodule

// File: rtl/restoring_divider_8by4.sv
// rtl/restoring_divider_8by4.sv - sequential restoring divider, one quotient bit per cycle
module restoring_divider_8by4
  import divider_pkg::*;
#(
  parameter int DIVIDEND_W = DIVIDEND_W_DEF,
  parameter int DIVISOR_W  = DIVISOR_W_DEF
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic [DIVIDEND_W-1:0] dividend,
  input  logic [DIVISOR_W-1:0]  divisor,
  output logic                  busy,
  output logic                  done,
  output logic [DIVIDEND_W-1:0] quotient,
  output logic [DIVISOR_W-1:0]  remainder,
  output logic                  div_by_zero
);

  localparam int CNT_W = $clog2(DIVIDEND_W + 1);

  div_state_t state, state_nxt;

  logic [DIVIDEND_W-1:0] q_reg;
  logic [DIVIDEND_W-1:0] q_nxt;
  logic [DIVISOR_W-1:0]  r_reg;
  logic [DIVISOR_W-1:0]  r_step;
  logic [DIVISOR_W-1:0]  dvs_reg;
  logic [CNT_W-1:0]      cnt;
  logic                  q_bit;
  logic                  accept;
  logic                  zero_div;
  logic                  last_step;

  assign zero_div  = (dvs_reg == '0);
  assign last_step = (cnt == CNT_W'(1));
  assign q_nxt     = {q_reg[DIVIDEND_W-2:0], q_bit};

  // Partial remainder shifted left with the next dividend bit pulled in from Q's MSB.
  div_step #(
    .DIVISOR_W (DIVISOR_W)
  ) u_step (
    .r_in    ({r_reg, q_reg[DIVIDEND_W-1]}),
    .divisor (dvs_reg),
    .r_out   (r_step),
    .q_bit   (q_bit)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= ST_IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    accept    = 1'b0;
    busy      = 1'b0;
    done      = 1'b0;
    case (state)
      ST_IDLE: begin
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        busy = 1'b1;
        if (zero_div || last_step) begin
          state_nxt = ST_DONE;
        end
      end
      ST_DONE: begin
        done = 1'b1;
        if (start) begin
          accept    = 1'b1;
          state_nxt = ST_RUN;
        end else begin
          state_nxt = ST_IDLE;
        end
      end
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      q_reg       <= '0;
      r_reg       <= '0;
      dvs_reg     <= '0;
      cnt         <= '0;
      quotient    <= '0;
      remainder   <= '0;
      div_by_zero <= 1'b0;
    end else if (accept) begin
      q_reg       <= dividend;
      r_reg       <= '0;
      dvs_reg     <= divisor;
      cnt         <= CNT_W'(DIVIDEND_W);
      div_by_zero <= 1'b0;
    end else if (state == ST_RUN) begin
      if (zero_div) begin
        // q_reg still holds the untouched dividend here.
        quotient    <= '1;
        remainder   <= q_reg[DIVISOR_W-1:0];
        div_by_zero <= 1'b1;
        cnt         <= '0;
      end else begin
        q_reg <= q_nxt;
        r_reg <= r_step;
        cnt   <= cnt - 1'b1;
        if (last_step) begin
          quotient  <= q_nxt;
          remainder <= r_step;
        end
      end
    end
  end

endmodule
